// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - instruction register types plus issue-queue sizing
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam int IR_DEPTH = 32;

  typedef logic [5:0] iq_count_t;

endpackage

// File: rtl/instr_issue_ctrl_if.sv
// rtl/instr_issue_ctrl_if.sv - producer, register and consumer signals of the issue controller
interface instr_issue_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  import instr_register_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  instruction_t       req_instr [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;

  logic               load_en;
  address_t           write_pointer;
  opcode_t            opcode;
  operand_t           operand_a;
  operand_t           operand_b;
  address_t           read_pointer;
  instruction_t       instruction_word;

  logic               iss_valid;
  logic               iss_ready;
  instruction_t       iss_instr;
  logic [SRC_W-1:0]   iss_src;

  iq_count_t          count;
  logic               full;
  logic               empty;

  modport master (
    input  req_valid, req_instr, instruction_word, iss_ready,
    output req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
    output read_pointer, iss_valid, iss_instr, iss_src, count, full, empty
  );

  modport slave (
    output req_valid, req_instr, instruction_word, iss_ready,
    input  req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
    input  read_pointer, iss_valid, iss_instr, iss_src, count, full, empty
  );

endinterface

// File: rtl/instr_issue_ctrl_rr_arbiter.sv
// rtl/instr_issue_ctrl_rr_arbiter.sv - combinational round-robin arbiter, one-hot grant
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  // Visit requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// rtl/instr_issue_ctrl.sv - circular issue queue over the instruction register
// Arbitrates producers onto the register write port and issues the oldest entry.
module instr_issue_ctrl #(
  parameter int DEPTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  instr_issue_ctrl_if.master  bus
);
  import instr_register_pkg::*;

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DEPTH < 2 || DEPTH > IR_DEPTH) begin : g_bad_depth
    $error("instr_issue_ctrl: DEPTH must be within 2..IR_DEPTH");
  end
  if (NUM_REQ < 1 || NUM_REQ > 4) begin : g_bad_num_req
    $error("instr_issue_ctrl: NUM_REQ must be within 1..4");
  end

  address_t         wr_ptr_q, wr_ptr_d;
  address_t         rd_ptr_q, rd_ptr_d;
  iq_count_t        count_q, count_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] src_tag_q [IR_DEPTH];
  logic [SRC_W-1:0] src_tag_d [IR_DEPTH];

  logic               full, empty;
  logic               allow_wr;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   win_idx;
  instruction_t       gnt_instr;
  logic               wr_fire, iss_valid, iss_fire;

  assign full  = (count_q == iq_count_t'(DEPTH));
  assign empty = (count_q == '0);

  // reset_n gates the grant so req_ready stays low while reset is held.
  assign allow_wr   = !full && !flush && reset_n;
  assign req_masked = bus.req_valid & {NUM_REQ{allow_wr}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req (req_masked),
    .ptr (rr_ptr_q),
    .gnt (grant)
  );

  always_comb begin
    win_idx   = '0;
    gnt_instr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx   = SRC_W'(i);
        gnt_instr = bus.req_instr[i];
      end
    end
  end

  assign wr_fire   = |grant;
  assign iss_valid = !empty && !flush;
  assign iss_fire  = iss_valid && bus.iss_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rr_ptr_d  = rr_ptr_q;
    src_tag_d = src_tag_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rr_ptr_d = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = (wr_ptr_q == address_t'(DEPTH - 1)) ? '0 : wr_ptr_q + 5'd1;
        src_tag_d[wr_ptr_q] = win_idx;
        rr_ptr_d = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (iss_fire) begin
        rd_ptr_d = (rd_ptr_q == address_t'(DEPTH - 1)) ? '0 : rd_ptr_q + 5'd1;
      end
      case ({wr_fire, iss_fire})
        2'b10:   count_d = count_q + 6'd1;
        2'b01:   count_d = count_q - 6'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Source tags mirror the register array: contents survive reset and flush.
  always_ff @(posedge clk) begin
    src_tag_q <= src_tag_d;
  end

  assign bus.req_ready     = grant;
  assign bus.load_en       = wr_fire;
  assign bus.write_pointer = wr_ptr_q;
  assign bus.opcode        = gnt_instr.opc;
  assign bus.operand_a     = gnt_instr.op_a;
  assign bus.operand_b     = gnt_instr.op_b;
  assign bus.read_pointer  = rd_ptr_q;
  assign bus.iss_valid     = iss_valid;
  assign bus.iss_instr     = bus.instruction_word;
  assign bus.iss_src       = src_tag_q[rd_ptr_q];
  assign bus.count         = count_q;
  assign bus.full          = full;
  assign bus.empty         = empty;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// tb/tb_instr_issue_ctrl.sv - directed self-checking bench for instr_issue_ctrl
module tb_instr_issue_ctrl;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  instr_issue_ctrl_if #(.NUM_REQ(2)) bus();

  instr_issue_ctrl #(
    .DEPTH   (32),
    .NUM_REQ (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  instruction_t mem [32];

  always @(posedge clk) begin
    if (bus.load_en) mem[bus.write_pointer] <= {bus.opcode, bus.operand_a, bus.operand_b};
  end

  assign bus.instruction_word = mem[bus.read_pointer];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    bus.req_valid = 2'b00;
    bus.iss_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  instruction_t i_add, i_sub, i_mul, i_pa, i_sb;

  initial begin
    i_add = '{opc: ADD,   op_a: 3,  op_b: 5};
    i_sub = '{opc: SUB,   op_a: 10, op_b: 1};
    i_mul = '{opc: MULT,  op_a: 20, op_b: 2};
    i_pa  = '{opc: PASSA, op_a: 7,  op_b: 0};
    i_sb  = '{opc: SUB,   op_a: 9,  op_b: 4};

    reset_n = 1'b0;
    flush   = 1'b0;
    bus.iss_ready    = 1'b0;
    bus.req_valid    = 2'b11;
    bus.req_instr[0] = i_add;
    bus.req_instr[1] = i_mul;
    #2;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_load_en", bus.load_en, 1'b0);
    chk("rst_count", bus.count, 6'd0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_iss_valid", bus.iss_valid, 1'b0);
    chk("rst_wp", bus.write_pointer, 5'd0);
    chk("rst_rp", bus.read_pointer, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single write from producer 0
    bus.req_valid = 2'b01;
    #1;
    chk("t1_load_en", bus.load_en, 1'b1);
    chk("t1_wp", bus.write_pointer, 5'd0);
    chk("t1_req_ready", bus.req_ready, 2'b01);
    chk("t1_opcode", bus.opcode, ADD);
    tick();
    bus.req_valid = 2'b00;
    chk("t1_iss_valid", bus.iss_valid, 1'b1);
    chk("t1_iss_instr", bus.iss_instr, i_add);
    chk("t1_iss_src", bus.iss_src, 1'b0);
    chk("t1_count", bus.count, 6'd1);

    // alternating grants
    do_flush();
    bus.req_instr[0] = i_sub;
    bus.req_instr[1] = i_mul;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_grant%0d", k), bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2_wp%0d", k), bus.write_pointer, k);
      tick();
    end
    bus.req_valid = 2'b00;
    chk("t2_count", bus.count, 6'd4);
    chk("t2_head_instr", bus.iss_instr, i_sub);
    chk("t2_head_src", bus.iss_src, 1'b0);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    chk("t2_next_src", bus.iss_src, 1'b1);
    chk("t2_next_instr", bus.iss_instr, i_mul);
    chk("t2_count_after", bus.count, 6'd3);

    // fill to full, blocked grant, wrap
    do_flush();
    bus.req_valid = 2'b11;
    for (int k = 0; k < 32; k++) tick();
    chk("t3_count_full", bus.count, 6'd32);
    chk("t3_full", bus.full, 1'b1);
    bus.iss_ready = 1'b1;
    #1;
    chk("t3_req_ready_full", bus.req_ready, 2'b00);
    chk("t3_load_en_full", bus.load_en, 1'b0);
    chk("t3_iss_valid_full", bus.iss_valid, 1'b1);
    tick();
    bus.iss_ready = 1'b0;
    chk("t3_count_31", bus.count, 6'd31);
    chk("t3_full_clear", bus.full, 1'b0);
    #1;
    chk("t3_wrap_load_en", bus.load_en, 1'b1);
    chk("t3_wrap_wp", bus.write_pointer, 5'd0);
    chk("t3_wrap_grant", bus.req_ready, 2'b01);
    chk("t3_rp", bus.read_pointer, 5'd1);
    tick();
    bus.req_valid = 2'b00;
    chk("t3_count_refill", bus.count, 6'd32);

    // simultaneous write and issue at count 1
    do_flush();
    bus.req_instr[0] = i_pa;
    bus.req_valid = 2'b01;
    tick();
    bus.req_instr[0] = i_sb;
    chk("t4_count1", bus.count, 6'd1);
    bus.iss_ready = 1'b1;
    #1;
    chk("t4_load_en", bus.load_en, 1'b1);
    chk("t4_wp", bus.write_pointer, 5'd1);
    chk("t4_rp", bus.read_pointer, 5'd0);
    chk("t4_head", bus.iss_instr, i_pa);
    tick();
    bus.req_valid = 2'b00;
    bus.iss_ready = 1'b0;
    chk("t4_count_hold", bus.count, 6'd1);
    chk("t4_rp_adv", bus.read_pointer, 5'd1);
    chk("t4_wp_adv", bus.write_pointer, 5'd2);
    chk("t4_head2", bus.iss_instr, i_sb);

    // flush with count 5, rr_ptr left at 1
    do_flush();
    bus.req_instr[0] = i_sub;
    bus.req_valid = 2'b01;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_count5", bus.count, 6'd5);
    flush = 1'b1;
    bus.req_valid = 2'b11;
    bus.iss_ready = 1'b1;
    #1;
    chk("t5_req_ready", bus.req_ready, 2'b00);
    chk("t5_load_en", bus.load_en, 1'b0);
    chk("t5_iss_valid", bus.iss_valid, 1'b0);
    tick();
    flush = 1'b0;
    bus.iss_ready = 1'b0;
    chk("t5_count0", bus.count, 6'd0);
    chk("t5_wp0", bus.write_pointer, 5'd0);
    chk("t5_rp0", bus.read_pointer, 5'd0);
    chk("t5_empty", bus.empty, 1'b1);
    #1;
    chk("t5_rr_reset", bus.req_ready, 2'b01);

    // asynchronous reset at count 7
    for (int k = 0; k < 7; k++) tick();
    chk("t6_count7", bus.count, 6'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_req_ready", bus.req_ready, 2'b00);
    chk("t6_load_en", bus.load_en, 1'b0);
    chk("t6_count", bus.count, 6'd0);
    chk("t6_empty", bus.empty, 1'b1);
    chk("t6_full", bus.full, 1'b0);
    chk("t6_iss_valid", bus.iss_valid, 1'b0);
    chk("t6_wp", bus.write_pointer, 5'd0);
    chk("t6_rp", bus.read_pointer, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t6_rel_load_en", bus.load_en, 1'b1);
    chk("t6_rel_wp", bus.write_pointer, 5'd0);
    chk("t6_rel_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    chk("t6_rel_count", bus.count, 6'd1);
    chk("t6_rel_instr", bus.iss_instr, i_sub);
    chk("t6_rel_src", bus.iss_src, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
